add: RTL and testbench

ADD -- requirements
Module: add

---
 rtl/add.sv | 63 ++++++
 tb/tb_add.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/add.sv
// Unsigned WIDTH-bit adder with optionally registered sum/carry/zero outputs,
// a post-reset valid flag and a saturating count of carry-out cycles.
module add #(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 1,
  parameter int CNT_W      = 16
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic [WIDTH-1:0] answer,
  output logic             carry,
  output logic             zero,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, input_a} + {1'b0, input_b};

  generate
    if (REGISTERED != 0) begin : g_reg
      always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
          answer <= '0;
          carry  <= 1'b0;
          zero   <= 1'b1;
        end else begin
          answer <= full_sum[WIDTH-1:0];
          carry  <= full_sum[WIDTH];
          zero   <= (full_sum == '0);
        end
      end
    end else begin : g_comb
      // Combinational path ignores irst entirely.
      always_comb begin
        answer = full_sum[WIDTH-1:0];
        carry  = full_sum[WIDTH];
        zero   = (full_sum == '0);
      end
    end
  endgenerate

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b1;
    end
  end

  // Counts from the live carry, so it is the same whichever output mode is built.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      carry_count <= '0;
    end else if (full_sum[WIDTH] && (carry_count != '1)) begin
      carry_count <= carry_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_add.sv
// Directed bench for add: half adder, 8-bit registered adder with a 4-bit
// saturating counter, and the combinational build.
`timescale 1ns/1ps
module tb_add;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a1 = 1'b0, b1 = 1'b0;
  logic       ans1, c1, z1, v1;
  logic [15:0] cnt1;

  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] ans8;
  logic       c8, z8, v8;
  logic [3:0] cnt8;

  logic       a0 = 1'b0, b0 = 1'b0;
  logic       ans0, c0, z0, v0;
  logic [15:0] cnt0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  add #(.WIDTH(1), .REGISTERED(1), .CNT_W(16)) u_half (
    .iclk(clk), .irst(rst), .input_a(a1), .input_b(b1),
    .answer(ans1), .carry(c1), .zero(z1), .out_valid(v1), .carry_count(cnt1)
  );

  add #(.WIDTH(8), .REGISTERED(1), .CNT_W(4)) u_byte (
    .iclk(clk), .irst(rst), .input_a(a8), .input_b(b8),
    .answer(ans8), .carry(c8), .zero(z8), .out_valid(v8), .carry_count(cnt8)
  );

  add #(.WIDTH(1), .REGISTERED(0), .CNT_W(16)) u_comb (
    .iclk(clk), .irst(rst), .input_a(a0), .input_b(b0),
    .answer(ans0), .carry(c0), .zero(z0), .out_valid(v0), .carry_count(cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held across edges with non-zero inputs.
    a1 = 1'b1; b1 = 1'b1; a8 = 8'd255; b8 = 8'd255; a0 = 1'b1; b0 = 1'b1;
    step();
    step();
    chk("rst_half_ans", ans1, 0);
    chk("rst_half_carry", c1, 0);
    chk("rst_half_zero", z1, 1);
    chk("rst_half_valid", v1, 0);
    chk("rst_half_cnt", cnt1, 0);
    chk("rst_byte_ans", ans8, 0);
    chk("rst_byte_zero", z8, 1);
    chk("rst_byte_cnt", cnt8, 0);
    chk("rst_comb_valid", v0, 0);
    chk("rst_comb_ans", ans0, 0);
    chk("rst_comb_carry", c0, 1);

    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'd200; b8 = 8'd100;
    step();
    chk("h00_ans", ans1, 0);
    chk("h00_carry", c1, 0);
    chk("h00_zero", z1, 1);
    chk("h00_valid", v1, 1);
    chk("b200_100_ans", ans8, 44);
    chk("b200_100_carry", c8, 1);
    chk("b_valid", v8, 1);
    a1 = 1'b1; b1 = 1'b0; a8 = 8'd255; b8 = 8'd1;
    #2;
    chk("b_hold_between_edges", ans8, 44);
    step();
    chk("h10_ans", ans1, 1);
    chk("h10_carry", c1, 0);
    chk("h10_zero", z1, 0);
    chk("b255_1_ans", ans8, 0);
    chk("b255_1_carry", c8, 1);
    chk("b255_1_zero", z8, 0);
    a1 = 1'b0; b1 = 1'b1; a8 = 8'd0; b8 = 8'd0;
    step();
    chk("h01_ans", ans1, 1);
    chk("h01_carry", c1, 0);
    chk("h01_zero", z1, 0);
    chk("b0_0_zero", z8, 1);
    chk("b0_0_carry", c8, 0);
    a1 = 1'b1; b1 = 1'b1;
    step();
    chk("h11_ans", ans1, 0);
    chk("h11_carry", c1, 1);
    chk("h11_zero", z1, 0);
    chk("h11_cnt", cnt1, 1);
    chk("b_cnt_two", cnt8, 2);

    a8 = 8'd128; b8 = 8'd128;
    for (int i = 0; i < 3; i++) step();
    chk("b_cnt_five", cnt8, 5);
    chk("b128_ans", ans8, 0);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b1;
    #1;
    chk("async_ans", ans8, 0);
    chk("async_carry", c8, 0);
    chk("async_zero", z8, 1);
    chk("async_valid", v8, 0);
    chk("async_cnt", cnt8, 0);
    step();
    chk("async_hold_cnt", cnt8, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rel_valid", v8, 1);
    chk("rel_cnt", cnt8, 1);
    for (int i = 0; i < 14; i++) step();
    chk("sat_cnt_15", cnt8, 15);
    for (int i = 0; i < 5; i++) step();
    chk("sat_cnt_stays", cnt8, 15);

    // Combinational build: a toggles every unit, b every three.
    for (int i = 0; i < 12; i++) begin
      a0 = 1'(i % 2);
      b0 = 1'((i / 3) % 2);
      #0.5;
      chk("comb_xor", ans0, 32'(a0 ^ b0));
      chk("comb_and", c0, 32'(a0 & b0));
      chk("comb_zero", z0, 32'(!(a0 | b0)));
      #0.5;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
